// File: rtl/mdr_datapath_pkg.sv
// Shared types for the MDR arithmetic datapath: operation codes, iteration
// counts and the working-register bundle stepped by mdr_step.
package system_mdr_pkg;

  localparam int unsigned MDR_DW = 8;
  localparam int unsigned N_MUL  = MDR_DW;
  localparam int unsigned N_DIV  = MDR_DW;
  localparam int unsigned N_SQRT = MDR_DW / 2;
  localparam int unsigned IW     = $clog2(MDR_DW + 1);

  typedef enum logic [1:0] {
    MUL     = 2'b00,
    DIV     = 2'b01,
    SQRT    = 2'b10,
    OP_RSVD = 2'b11
  } e_mdr_op;

  // Working registers for all three algorithms; only the fields of the
  // active op are meaningful between veri and ready.
  typedef struct packed {
    logic [2*MDR_DW:0]   p;
    logic [MDR_DW:0]     r;
    logic [MDR_DW-1:0]   q;
    logic [MDR_DW-1:0]   rem;
    logic [MDR_DW/2-1:0] root;
    logic [MDR_DW-1:0]   rad;
    logic [IW-1:0]       iter;
  } st_datapath;

  function automatic logic [IW-1:0] n_iter(input e_mdr_op op);
    case (op)
      DIV:     return IW'(N_DIV);
      SQRT:    return IW'(N_SQRT);
      default: return IW'(N_MUL);
    endcase
  endfunction

endpackage

// File: rtl/mdr_datapath_if.sv
// Strobe/operand/result bundle between the MDR controller and the datapath.
interface mdr_datapath_if #(parameter int unsigned DW = 8);
  logic            clean;
  logic            loadX;
  logic            loadY;
  logic            veri;
  logic            enable;
  logic            ready;
  logic [1:0]      op_in;
  logic [DW-1:0]   data_in;
  logic            w_error;
  logic [2*DW-1:0] result;
  logic [DW-1:0]   remainder;
  logic            result_valid;
  logic            done;

  modport master (
    output clean, loadX, loadY, veri, enable, ready, op_in, data_in,
    input  w_error, result, remainder, result_valid, done
  );

  modport slave (
    input  clean, loadX, loadY, veri, enable, ready, op_in, data_in,
    output w_error, result, remainder, result_valid, done
  );
endinterface

// File: rtl/mdr_datapath_step.sv
// Combinational single iteration of shift-add multiply, restoring divide or
// digit-by-digit square root; also advances the iteration counter.
module mdr_step
  import system_mdr_pkg::*;
(
  input  e_mdr_op           op,
  input  st_datapath        cur,
  input  logic [MDR_DW-1:0] x,
  input  logic [MDR_DW-1:0] y,
  output st_datapath        nxt
);
  localparam int unsigned DW = MDR_DW;

  logic [DW:0]   mul_hi;
  logic [DW+1:0] div_t;
  logic [DW+1:0] sq_rem;
  logic [DW+1:0] sq_trial;

  always_comb begin
    nxt      = cur;
    nxt.iter = cur.iter + IW'(1);
    mul_hi   = '0;
    div_t    = '0;
    sq_rem   = '0;
    sq_trial = '0;
    unique case (op)
      MUL: begin
        mul_hi = cur.p[2*DW:DW] + (cur.p[0] ? {1'b0, x} : '0);
        nxt.p  = {1'b0, mul_hi, cur.p[DW-1:1]};
      end
      DIV: begin
        // R stays below Y, so the widened shift never loses a set bit
        div_t = {cur.r, cur.q[DW-1]};
        nxt.q = {cur.q[DW-2:0], 1'b0};
        if (div_t >= {2'b00, y}) begin
          nxt.r    = (DW+1)'(div_t - {2'b00, y});
          nxt.q[0] = 1'b1;
        end else begin
          nxt.r = div_t[DW:0];
        end
      end
      SQRT: begin
        sq_rem   = {cur.rem, cur.rad[DW-1:DW-2]};
        sq_trial = {{(DW/2){1'b0}}, cur.root, 2'b01};
        nxt.rad  = {cur.rad[DW-3:0], 2'b00};
        if (sq_rem >= sq_trial) begin
          nxt.rem  = DW'(sq_rem - sq_trial);
          nxt.root = (DW/2)'({cur.root, 1'b1});
        end else begin
          nxt.rem  = sq_rem[DW-1:0];
          nxt.root = (DW/2)'({cur.root, 1'b0});
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mdr_datapath.sv
// MDR arithmetic datapath: captures operands, flags operand errors during
// verification, iterates mul/div/sqrt on enable and publishes on ready.
module mdr_datapath
  import system_mdr_pkg::*;
#(
  parameter int unsigned DW = MDR_DW
) (
  input  logic          clk,
  input  logic          rst,
  mdr_datapath_if.slave bus
);
  e_mdr_op         op_r;
  logic [DW-1:0]   x_r;
  logic [DW-1:0]   y_r;
  st_datapath      dp;
  st_datapath      dp_nxt;
  st_datapath      dp_init;
  logic            err_r;
  logic            w_err;
  logic [2*DW-1:0] result_r;
  logic [DW-1:0]   rem_r;
  logic            valid_r;
  logic            done_r;

  assign w_err = bus.veri & (((op_r == DIV) && (y_r == '0)) || (op_r == OP_RSVD));

  mdr_step u_step (
    .op  (op_r),
    .cur (dp),
    .x   (x_r),
    .y   (y_r),
    .nxt (dp_nxt)
  );

  always_comb begin
    dp_init = '0;
    unique case (op_r)
      MUL:     dp_init.p   = {{(DW+1){1'b0}}, y_r};
      DIV:     dp_init.q   = x_r;
      SQRT:    dp_init.rad = x_r;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r     <= MUL;
      x_r      <= '0;
      y_r      <= '0;
      dp       <= '0;
      err_r    <= 1'b0;
      result_r <= '0;
      rem_r    <= '0;
      valid_r  <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (bus.clean) begin
        op_r     <= MUL;
        x_r      <= '0;
        y_r      <= '0;
        dp       <= '0;
        err_r    <= 1'b0;
        result_r <= '0;
        rem_r    <= '0;
        done_r   <= 1'b0;
      end else if (bus.veri) begin
        err_r  <= w_err;
        dp     <= dp_init;
        done_r <= 1'b0;
      end else if (bus.loadX) begin
        x_r  <= bus.data_in;
        op_r <= e_mdr_op'(bus.op_in);
      end else if (bus.loadY) begin
        y_r <= bus.data_in;
      end else if (bus.enable) begin
        // surplus enables after the last iteration, or after an error, hold
        if (!err_r && (dp.iter < n_iter(op_r))) begin
          dp     <= dp_nxt;
          done_r <= (dp_nxt.iter == n_iter(op_r));
        end
      end else if (bus.ready) begin
        valid_r <= 1'b1;
        if (err_r) begin
          result_r <= '0;
          rem_r    <= '0;
        end else begin
          unique case (op_r)
            MUL: begin
              result_r <= dp.p[2*DW-1:0];
              rem_r    <= '0;
            end
            DIV: begin
              result_r <= {{DW{1'b0}}, dp.q};
              rem_r    <= dp.r[DW-1:0];
            end
            SQRT: begin
              result_r <= {{(DW + DW/2){1'b0}}, dp.root};
              rem_r    <= dp.rem;
            end
            default: begin
              result_r <= '0;
              rem_r    <= '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.w_error      = w_err;
  assign bus.result       = result_r;
  assign bus.remainder    = rem_r;
  assign bus.result_valid = valid_r;
  assign bus.done         = done_r;
endmodule

// File: tb/tb_mdr_datapath.sv
// Directed bench for mdr_datapath: expected results are queued at ready and
// checked by a monitor whenever result_valid is seen.
module tb_mdr_datapath;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mdr_datapath_if #(.DW(8)) bus ();

  mdr_datapath #(.DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [15:0] res;
    logic [7:0]  rem;
    logic        done;
  } exp_t;

  exp_t expq[$];
  int   total  = 0;
  int   bad    = 0;
  int   pushed = 0;
  int   popped = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every result_valid cycle must match the oldest queued result
  exp_t e;
  always @(negedge clk) begin
    if (bus.result_valid === 1'b1) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got result=%0d with no queued expectation", bus.result);
      end else begin
        e = expq.pop_front();
        popped++;
        chk("sb_result", 32'(bus.result), 32'(e.res));
        chk("sb_remainder", 32'(bus.remainder), 32'(e.rem));
        chk("sb_done", 32'(bus.done), 32'(e.done));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] x, input logic [7:0] y, input logic [1:0] op,
                      input logic exp_err);
    bus.loadX = 1'b1; bus.data_in = x; bus.op_in = op;
    tick();
    bus.loadX = 1'b0;
    bus.loadY = 1'b1; bus.data_in = y;
    tick();
    bus.loadY = 1'b0;
    bus.veri  = 1'b1;
    #1;
    chk("w_error_veri", 32'(bus.w_error), 32'(exp_err));
    tick();
    bus.veri = 1'b0;
  endtask

  task automatic run(input int n);
    bus.enable = 1'b1;
    repeat (n) tick();
    bus.enable = 1'b0;
  endtask

  task automatic publish(input logic [15:0] res, input logic [7:0] rem, input logic dn);
    exp_t x;
    x.res = res; x.rem = rem; x.done = dn;
    expq.push_back(x);
    pushed++;
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    tick();
  endtask

  initial begin
    bus.clean = 0; bus.loadX = 0; bus.loadY = 0; bus.veri = 0;
    bus.enable = 0; bus.ready = 0; bus.op_in = 2'b00; bus.data_in = '0;
    #12;
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_remainder", 32'(bus.remainder), 0);
    chk("rst_valid", 32'(bus.result_valid), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_w_error", 32'(bus.w_error), 0);
    rst = 1'b1;
    tick();

    // MUL 13*11 with the controller's DW+1 enables
    load(8'd13, 8'd11, 2'b00, 1'b0);
    run(9);
    chk("mul_done", 32'(bus.done), 1);
    publish(16'd143, 8'd0, 1'b1);

    // MUL boundary; the extra enable must not disturb the product
    load(8'd255, 8'd255, 2'b00, 1'b0);
    run(8);
    publish(16'd65025, 8'd0, 1'b1);
    run(1);
    publish(16'd65025, 8'd0, 1'b1);

    // DIV 100/7
    load(8'd100, 8'd7, 2'b01, 1'b0);
    run(9);
    publish(16'd14, 8'd2, 1'b1);

    // DIV by zero: error flagged, enables ignored, zero result
    load(8'd50, 8'd0, 2'b01, 1'b1);
    run(9);
    chk("div0_done", 32'(bus.done), 0);
    chk("w_error_idle", 32'(bus.w_error), 0);
    publish(16'd0, 8'd0, 1'b0);

    // SQRT 200: done after exactly N_SQRT enables
    load(8'd200, 8'd0, 2'b10, 1'b0);
    run(3);
    chk("sqrt_done_early", 32'(bus.done), 0);
    run(1);
    chk("sqrt_done", 32'(bus.done), 1);
    publish(16'd14, 8'd4, 1'b1);
    run(5);
    publish(16'd14, 8'd4, 1'b1);

    // reserved op
    load(8'd9, 8'd3, 2'b11, 1'b1);
    publish(16'd0, 8'd0, 1'b0);

    // async reset mid-calculation with a stale result present
    load(8'd13, 8'd11, 2'b00, 1'b0);
    run(9);
    publish(16'd143, 8'd0, 1'b1);
    load(8'd7, 8'd9, 2'b00, 1'b0);
    run(3);
    rst = 1'b0;
    #1;
    chk("midrst_result", 32'(bus.result), 0);
    chk("midrst_remainder", 32'(bus.remainder), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_valid", 32'(bus.result_valid), 0);
    tick();
    rst = 1'b1;
    tick();

    // clean clears a stale result, and wins over a simultaneous ready
    load(8'd13, 8'd11, 2'b00, 1'b0);
    run(9);
    publish(16'd143, 8'd0, 1'b1);
    bus.clean = 1'b1;
    bus.ready = 1'b1;
    tick();
    bus.clean = 1'b0;
    bus.ready = 1'b0;
    chk("clean_result", 32'(bus.result), 0);
    chk("clean_remainder", 32'(bus.remainder), 0);
    chk("clean_done", 32'(bus.done), 0);
    chk("clean_valid", 32'(bus.result_valid), 0);

    tick();
    tick();
    chk("sb_drained", 32'(popped), 32'(pushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdr_datapath.md
Name: mdr_datapath

Overview:
- Arithmetic datapath directly downstream of the MDR control FSM. It consumes the controller's one-hot strobes (clean, loadX, loadY, veri, enable, ready).
- It captures two unsigned operands and reports operand errors back to the controller during verification.
- It runs one multiply, divide or square-root iteration per enable cycle, then publishes the registered result on ready.

Parameters:
DW, 8, operand width in bits; must be even and >= 4 (square root needs DW/2 iterations).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
clean  in  1  clear all datapath state (from controller)
loadX  in  1  capture data_in into X and op_in into op register
loadY  in  1  capture data_in into Y
veri  in  1  verification cycle; initialise working registers
enable  in  1  perform one iteration per cycle
ready  in  1  publish result
op_in  in  2  operation: 00 MUL, 01 DIV, 10 SQRT, 11 reserved
data_in  in  DW  operand bus
w_error  out  1  operand error, combinational, valid during veri
result  out  2*DW  product / zero-extended quotient / zero-extended root
remainder  out  DW  division or root remainder; 0 for MUL
result_valid  out  1  one-cycle pulse, the cycle after ready
done  out  1  iteration count reached for current op

Behaviour:
- Reset (rst=0, async): every register is 0, including X, Y, op, working regs, iteration counter, err flag, result, remainder, result_valid and done. w_error=0.
- Strobe priority in a given cycle: clean > veri > loadX > loadY > enable > ready. The controller is one-hot, but overlapping strobes must still resolve by this priority.
- clean: zeroes X, Y, op, working regs, iter, err flag, done, result, remainder and result_valid on the next edge.
- loadX: X <= data_in, op_r <= op_in. loadY: Y <= data_in. Neither strobe affects result or remainder.
- w_error is combinational: veri & ((op_r==DIV & Y==0) | op_r==11). On that edge err_r <= w_error, so the controller sees the error in the same VERIFICATION cycle.
- veri initialisation, by op:
  - MUL: P[2DW:0] <= {0, Y}.
  - DIV: R[DW:0] <= 0, Q <= X.
  - SQRT: rem <= 0, root <= 0, radicand shift reg <= X.
  - All ops: iter <= 0, done <= 0.
- Iteration count N: MUL = DW, DIV = DW, SQRT = DW/2.
- enable with err_r=0 and iter<N: one step, then iter <= iter+1. done <= 1 when iter+1 == N.
  - MUL (shift-add): if P[0], upper half of P += X with carry; then shift P right by 1.
  - DIV (restoring): shift {R,Q} left; if R >= Y then R -= Y, Q[0] <= 1.
  - SQRT (digit-by-digit): bring down 2 radicand MSBs; trial = {root,01}; if rem >= trial then subtract and shift in 1, else shift in 0.
- enable with iter==N or err_r=1: hold all state. The controller issues DW+1 enable cycles, so the surplus cycle must be a no-op.
- ready: on the next edge result/remainder load from the working regs, and result_valid pulses high for exactly 1 cycle.
  - MUL: result = P[2DW-1:0], remainder = 0.
  - DIV: result = {0, Q}, remainder = R[DW-1:0].
  - SQRT: result = {0, root} (root is DW/2 bits, zero-extended), remainder = rem[DW-1:0].
  - If err_r=1, result and remainder are forced to 0.
  - result/remainder hold until the next clean, ready or reset.
- All arithmetic is unsigned. No overflow is possible: a product fits in 2DW bits and the root remainder is <= 2*root < 2^DW.
- Reset asserted mid-calculation: immediate clear. A calculation is never resumed after reset.

Decomposition:
- Package system_mdr_pkg gains:
  - enum e_mdr_op {MUL=2'b00, DIV=2'b01, SQRT=2'b10, OP_RSVD=2'b11}
  - localparams N_MUL=DW, N_DIV=DW, N_SQRT=DW/2
  - struct st_datapath holding the working registers
- Sub-module mdr_step: purely combinational single-iteration unit (inputs op, working regs, X, Y; outputs next working regs). Instantiated once, with its outputs registered in mdr_datapath.

Test Plan (DW=8):
- MUL: X=13, Y=11, veri, 9 enables, ready -> result=16'd143, remainder=0, done=1, result_valid pulses 1 cycle.
- MUL boundary: X=255, Y=255 -> result=16'd65025. The 9th enable is a no-op; the result is unchanged versus 8 enables.
- DIV: X=100, Y=7 -> w_error=0 during veri, result=16'd14, remainder=8'd2.
- DIV by zero: X=50, Y=0 -> w_error=1 in the veri cycle; subsequent enables ignored; ready gives result=0, remainder=0.
- SQRT: X=200 -> done after 4 enables, result=16'd14, remainder=8'd4. Also op=11 -> w_error=1.
- Reset/clean mid-op: rst=0 after 3 MUL enables -> all outputs 0 immediately. clean with stale result=143 -> result=0 next edge.
